mem_wb_regfile: RTL and testbench
=================================

Name: mem_wb_regfile

Overview:
Receiving end of the memory-stage write-back interface (wd/wreg/wdata).
- Registers the MEM outputs in a MEM/WB pipeline stage with stall and flush control.
- Commits the registered write into a 32x32 general register file.
- Serves two combinational read ports to decode, with write-through bypass and $0 hardwired to zero.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low (rst==0 resets)
stall  in  1  hold MEM/WB stage contents
flush  in  1  clear MEM/WB stage (insert bubble); priority over stall
wd_i  in  ADDR_W  destination register from MEM
wreg_i  in  1  write enable from MEM
wdata_i  in  DATA_W  write data from MEM
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data (combinational)
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 address
rdata2  out  DATA_W  read port 2 data (combinational)
wb_wd_o  out  ADDR_W  registered destination (also used for forwarding)
wb_wreg_o  out  1  registered write enable
wb_wdata_o  out  DATA_W  registered write data

Behaviour:
Reset (rst==0, asynchronous, takes effect without a clock edge):
- wb_wd_o=0, wb_wreg_o=0, wb_wdata_o=0.
- All NUM_REGS entries cleared to 0.
- rdata1=rdata2=0 while rst==0.

MEM/WB stage update on each rising edge with rst==1:
- flush=1: wd/wreg/wdata <= 0 (bubble); stall is ignored.
- else stall=1: hold all three.
- else: capture wd_i, wreg_i, wdata_i.

Register-file write, each rising edge with rst==1:
- If wb_wreg_o==1 and wb_wd_o!=0: reg[wb_wd_o] <= wb_wdata_o.
- The write uses the stage contents present before the edge.
- A write held by stall is rewritten on every stalled edge; this is idempotent.
- Writes to $0 are discarded; reg[0] reads as 0 at all times.

Read ports, combinational, evaluated independently for port k in priority order:
1. rst==0 -> 0
2. rek==0 -> 0
3. raddrk==0 -> 0
4. wb_wreg_o==1 and raddrk==wb_wd_o -> wb_wdata_o (bypass of the in-flight write)
5. otherwise reg[raddrk]

Latency:
- Value presented by MEM before edge N is captured at edge N.
- It is readable through the bypass during cycle N..N+1 and is in the array after edge N+1.

Boundary cases:
- Both ports may read the same address simultaneously; both get identical data.
- A read of the address being written returns the new data, never the stale value.
- Flush and stall together: flush wins.
- Reset asserted mid-write: the write is lost and all state is zero.
- Reset deassertion is synchronised externally; the block must not write on the edge coincident with deassertion if rst is still 0 at that edge.

Decomposition:
Shared defines header holds:
- RstEnable (1'b0), RstDisable.
- WriteEnable/WriteDisable, ReadEnable/ReadDisable.
- ZeroWord, NOPRegAddr.
- RegBus, RegAddrBus, RegNum.

Natural split:
- Top mem_wb_regfile contains the MEM/WB register and stall/flush logic.
- Sub-module regfile holds the array, write port, two read ports and bypass.
- regfile is reusable by later chapters.

Test Plan:
- Hold rst=0, toggle clk; drive wreg_i=1, wd_i=3, wdata_i=0xDEADBEEF -> all wb_* outputs 0; rdata1 with re1=1, raddr1=3 reads 0.
- rst=1; drive wd_i=5, wreg_i=1, wdata_i=0x12345678 for one cycle, then wreg_i=0.
  - After edge 1: re1=1, raddr1=5 -> 0x12345678 via bypass.
  - After edge 2: stage idle, still 0x12345678 from the array.
- Drive wd_i=0, wreg_i=1, wdata_i=0xFFFFFFFF, then run 2 edges -> raddr1=0 and raddr2=0 both read 0.
- Capture wd=7, data=0xA5A5A5A5; assert stall=1 for 3 edges while MEM drives wd=8, data=1.
  - wb_wd_o stays 7 throughout.
  - reg[8] stays 0 until stall drops.
  - After release, reg[8]=1.
- Drive stall=1 and flush=1 in the same cycle with wb_wreg_o=1 -> after the edge wb_wreg_o=0 and wb_wd_o=0; the pending write was still committed at that edge.
- Write reg[9]=0x55, then assert rst=0 asynchronously mid-cycle -> rdata1 (raddr1=9) becomes 0 immediately and stays 0 after rst=1.

Source files
------------

// File: rtl/mem_wb_regfile_pkg.sv
// Shared constants and bus types for the MEM/WB write-back path and the
// general register file.
package mem_wb_regfile_pkg;

    localparam int reg_w      = 32;
    localparam int reg_addr_w = 5;
    localparam int reg_num    = 32;

    localparam logic rst_enable    = 1'b0;
    localparam logic rst_disable   = 1'b1;
    localparam logic write_enable  = 1'b1;
    localparam logic write_disable = 1'b0;
    localparam logic read_enable   = 1'b1;
    localparam logic read_disable  = 1'b0;

    localparam logic [reg_w-1:0]      zero_word    = '0;
    localparam logic [reg_addr_w-1:0] nop_reg_addr = '0;

    typedef logic [reg_w-1:0]      reg_bus_t;
    typedef logic [reg_addr_w-1:0] reg_addr_bus_t;

endpackage

// File: rtl/mem_wb_regfile_regfile.sv
// General register file: one write port, two combinational read ports with
// write-through bypass, and register $0 hardwired to zero.
module regfile
    import mem_wb_regfile_pkg::*;
#(
    parameter int DATA_W   = reg_w,
    parameter int ADDR_W   = reg_addr_w,
    parameter int NUM_REGS = reg_num
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Array write: clear everything on reset, never store into $0.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == rst_enable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we == write_enable && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1: reset, disable and $0 force zero; an in-flight write to
    // the same address wins over the stale array contents.
    always_comb begin
        rdata1 = '0;
        if (rst == rst_enable) begin
            rdata1 = '0;
        end else if (re1 == read_disable) begin
            rdata1 = '0;
        end else if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we == write_enable && raddr1 == waddr) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    // Read port 2: same priority as port 1, evaluated independently.
    always_comb begin
        rdata2 = '0;
        if (rst == rst_enable) begin
            rdata2 = '0;
        end else if (re2 == read_disable) begin
            rdata2 = '0;
        end else if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we == write_enable && raddr2 == waddr) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: rtl/mem_wb_regfile.sv
// MEM/WB pipeline register with stall/flush control feeding the general
// register file. wb_wreg_o qualifies wb_wd_o/wb_wdata_o: the pair is a
// pending write only while wb_wreg_o is 1, and it is committed on the next
// rising edge (repeatedly while stalled, which is harmless).
module mem_wb_regfile
    import mem_wb_regfile_pkg::*;
#(
    parameter int DATA_W   = reg_w,
    parameter int ADDR_W   = reg_addr_w,
    parameter int NUM_REGS = reg_num
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o
);

    // Stage update: flush inserts a bubble and overrides stall; stall holds.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == rst_enable) begin
            wb_wd_o    <= '0;
            wb_wreg_o  <= write_disable;
            wb_wdata_o <= '0;
        end else if (flush) begin
            wb_wd_o    <= '0;
            wb_wreg_o  <= write_disable;
            wb_wdata_o <= '0;
        end else if (!stall) begin
            wb_wd_o    <= wd_i;
            wb_wreg_o  <= wreg_i;
            wb_wdata_o <= wdata_i;
        end
    end

    regfile #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_wreg_o),
        .waddr  (wb_wd_o),
        .wdata  (wb_wdata_o),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

endmodule

// File: tb/tb_mem_wb_regfile.sv
// Directed bench for mem_wb_regfile: the driver queues hand-computed
// expectations, a separate monitor pops and compares them on each sample.
module tb_mem_wb_regfile;

    localparam int W  = 32;
    localparam int AW = 5;

    localparam int SEL_RD1   = 0;
    localparam int SEL_RD2   = 1;
    localparam int SEL_WD    = 2;
    localparam int SEL_WREG  = 3;
    localparam int SEL_WDATA = 4;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          flush;
    logic [AW-1:0] wd_i;
    logic          wreg_i;
    logic [W-1:0]  wdata_i;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [W-1:0]  rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [W-1:0]  rdata2;
    logic [AW-1:0] wb_wd_o;
    logic          wb_wreg_o;
    logic [W-1:0]  wb_wdata_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    string        name_q[$];
    event         sample_ev;

    mem_wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .wb_wd_o    (wb_wd_o),
        .wb_wreg_o  (wb_wreg_o),
        .wb_wdata_o (wb_wdata_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: pop every queued expectation when a sample is requested
    always @(sample_ev) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] exp_v;
            logic [W-1:0] act_v;
            int           sel;
            string        nm;
            exp_v = exp_q.pop_front();
            sel   = sel_q.pop_front();
            nm    = name_q.pop_front();
            case (sel)
                SEL_RD1:   act_v = rdata1;
                SEL_RD2:   act_v = rdata2;
                SEL_WD:    act_v = {{(W-AW){1'b0}}, wb_wd_o};
                SEL_WREG:  act_v = {{(W-1){1'b0}}, wb_wreg_o};
                default:   act_v = wb_wdata_o;
            endcase
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s actual=%h expected=%h t=%0t", nm, act_v, exp_v, $time);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_v(input int sel, input logic [W-1:0] v, input string nm);
        sel_q.push_back(sel);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic fire();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic mem_drive(input logic [AW-1:0] wd, input logic wr, input logic [W-1:0] d);
        wd_i    = wd;
        wreg_i  = wr;
        wdata_i = d;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_drive(5'd3, 1'b1, 32'hDEADBEEF);
        re1 = 1'b1; raddr1 = 5'd3;
        re2 = 1'b1; raddr2 = 5'd0;

        // reset held across clock edges: nothing captured, reads zero
        step(); step();
        expect_v(SEL_WD,    32'd0, "rst_wb_wd");
        expect_v(SEL_WREG,  32'd0, "rst_wb_wreg");
        expect_v(SEL_WDATA, 32'd0, "rst_wb_wdata");
        expect_v(SEL_RD1,   32'd0, "rst_rd1");
        fire();

        // single write to r5: bypass then array
        rst = 1'b1;
        mem_drive(5'd5, 1'b1, 32'h12345678);
        raddr1 = 5'd5; raddr2 = 5'd5;
        step();
        mem_drive(5'd0, 1'b0, 32'h0);
        expect_v(SEL_WD,   32'd5,         "cap_wb_wd");
        expect_v(SEL_WREG, 32'd1,         "cap_wb_wreg");
        expect_v(SEL_RD1,  32'h12345678,  "bypass_rd1");
        expect_v(SEL_RD2,  32'h12345678,  "bypass_rd2_same_addr");
        fire();
        step();
        expect_v(SEL_WREG, 32'd0,         "idle_wb_wreg");
        expect_v(SEL_RD1,  32'h12345678,  "array_rd1");
        expect_v(SEL_RD2,  32'h12345678,  "array_rd2_same_addr");
        fire();
        re1 = 1'b0;
        expect_v(SEL_RD1,  32'd0,         "re1_off");
        fire();
        re1 = 1'b1;

        // write to $0 is discarded, including on the bypass path
        mem_drive(5'd0, 1'b1, 32'hFFFFFFFF);
        raddr1 = 5'd0; raddr2 = 5'd0;
        step();
        mem_drive(5'd0, 1'b0, 32'h0);
        expect_v(SEL_RD1, 32'd0, "r0_bypass_rd1");
        expect_v(SEL_RD2, 32'd0, "r0_bypass_rd2");
        fire();
        step();
        expect_v(SEL_RD1, 32'd0, "r0_array_rd1");
        expect_v(SEL_RD2, 32'd0, "r0_array_rd2");
        fire();

        // stall holds r7 write in the stage while MEM presents r8
        mem_drive(5'd7, 1'b1, 32'hA5A5A5A5);
        raddr1 = 5'd8; raddr2 = 5'd7;
        step();
        stall = 1'b1;
        mem_drive(5'd8, 1'b1, 32'h00000001);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_v(SEL_WD,  32'd7,        "stall_wb_wd");
            expect_v(SEL_RD1, 32'd0,        "stall_r8_zero");
            expect_v(SEL_RD2, 32'hA5A5A5A5, "stall_r7");
            fire();
        end
        stall = 1'b0;
        step();
        mem_drive(5'd0, 1'b0, 32'h0);
        expect_v(SEL_WD,  32'd8, "release_wb_wd");
        expect_v(SEL_RD1, 32'd1, "release_r8_bypass");
        fire();
        step();
        expect_v(SEL_RD1, 32'd1,        "release_r8_array");
        expect_v(SEL_RD2, 32'hA5A5A5A5, "release_r7_array");
        fire();

        // flush beats stall; the pending r10 write still commits
        mem_drive(5'd10, 1'b1, 32'h00000077);
        raddr1 = 5'd10; raddr2 = 5'd11;
        step();
        stall = 1'b1; flush = 1'b1;
        mem_drive(5'd11, 1'b1, 32'h00000088);
        step();
        expect_v(SEL_WREG,  32'd0,  "flush_wb_wreg");
        expect_v(SEL_WD,    32'd0,  "flush_wb_wd");
        expect_v(SEL_WDATA, 32'd0,  "flush_wb_wdata");
        expect_v(SEL_RD1,   32'h77, "flush_r10_committed");
        expect_v(SEL_RD2,   32'd0,  "flush_r11_dropped");
        fire();
        stall = 1'b0; flush = 1'b0;

        // r9 written, r12 in flight, then asynchronous reset mid-cycle
        mem_drive(5'd9, 1'b1, 32'h00000055);
        raddr1 = 5'd9; raddr2 = 5'd12;
        step();
        mem_drive(5'd12, 1'b1, 32'h00000099);
        step();
        mem_drive(5'd0, 1'b0, 32'h0);
        expect_v(SEL_RD1, 32'h55, "pre_rst_r9");
        expect_v(SEL_RD2, 32'h99, "pre_rst_r12_bypass");
        fire();
        rst = 1'b0;
        expect_v(SEL_RD1,  32'd0, "async_rst_r9");
        expect_v(SEL_RD2,  32'd0, "async_rst_r12");
        expect_v(SEL_WREG, 32'd0, "async_rst_wb_wreg");
        fire();
        step();
        rst = 1'b1;
        step();
        expect_v(SEL_RD1, 32'd0, "post_rst_r9");
        expect_v(SEL_RD2, 32'd0, "post_rst_r12");
        fire();
        step();

        // final report
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
